fan_tach_meter: RTL and testbench

FAN_TACH_METER -- requirements
Module: fan_tach_meter

---
 rtl/fan_tach_meter.sv | 137 +++++++++++++
 tb/tb_fan_tach_meter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fan_tach_meter.sv
// Fan tachometer: synchronises and deglitches the tach line, counts filtered
// falling edges per gate window and publishes a saturated count each window.
module fan_tach_meter #(
    parameter int ADC_BITWIDTH = 8,
    parameter int GATE_TICKS   = 10000,
    parameter int FILTER_LEN   = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    enable_i,
    input  logic                    tach_i,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    dataValid_STRB_o,
    output logic                    stall_o,
    output logic [1:0]              state_o
);

    localparam int WIN_W = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(GATE_TICKS - 1);
    localparam logic [FLT_W-1:0]        FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [ADC_BITWIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_COUNT  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic                    filt_q, filt_d;
    logic [FLT_W-1:0]        fcnt_q, fcnt_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic [ADC_BITWIDTH-1:0] ecnt_q, ecnt_d;
    logic [ADC_BITWIDTH-1:0] adc_q, adc_d;
    logic                    stall_q, stall_d;
    logic                    stb_q, stb_d;
    logic                    fall;
    logic [ADC_BITWIDTH-1:0] ecnt_inc;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            win_q   <= '0;
            ecnt_q  <= '0;
            adc_q   <= '0;
            stall_q <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            sync1_q <= tach_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            win_q   <= win_d;
            ecnt_q  <= ecnt_d;
            adc_q   <= adc_d;
            stall_q <= stall_d;
            stb_q   <= stb_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        filt_d   = filt_q;
        fcnt_d   = fcnt_q;
        win_d    = win_q;
        ecnt_d   = ecnt_q;
        adc_d    = adc_q;
        stall_d  = stall_q;
        stb_d    = 1'b0;
        fall     = 1'b0;
        ecnt_inc = ecnt_q;
        case (state_q)
            S_IDLE: begin
                fcnt_d = '0;
                win_d  = '0;
                ecnt_d = '0;
                if (enable_i) state_d = S_WARMUP;
            end
            S_WARMUP, S_COUNT: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                    win_d   = '0;
                    ecnt_d  = '0;
                end else if (clk_en_i) begin
                    // Any tick agreeing with the accepted level restarts the run.
                    if (sync2_q != filt_q) begin
                        if (fcnt_q == FLT_LAST) begin
                            filt_d = sync2_q;
                            fcnt_d = '0;
                            fall   = filt_q;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end else begin
                        fcnt_d = '0;
                    end
                    if (fall && ecnt_q != CNT_MAX) ecnt_inc = ecnt_q + 1'b1;
                    // An edge on the closing tick belongs to the closing window.
                    if (win_q == WIN_LAST) begin
                        win_d   = '0;
                        ecnt_d  = '0;
                        state_d = S_COUNT;
                        if (state_q == S_COUNT) begin
                            adc_d   = ecnt_inc;
                            stall_d = (ecnt_inc == '0);
                            stb_d   = 1'b1;
                        end
                    end else begin
                        win_d  = win_q + 1'b1;
                        ecnt_d = ecnt_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                fcnt_d  = '0;
                win_d   = '0;
                ecnt_d  = '0;
            end
        endcase
    end

    assign ADC_value_o      = adc_q;
    assign dataValid_STRB_o = stb_q;
    assign stall_o          = stall_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_fan_tach_meter.sv
// Directed bench: tach patterns are driven per enable tick and the expected
// publish values for each window are hand-derived per pattern.
module tb_fan_tach_meter;

    localparam int G   = 10;
    localparam int G2  = 1200;
    localparam int NOM = 0;
    localparam int GLI = 1;
    localparam int BND = 2;

    logic       clk = 1'b0, rstn = 1'b0, clk_en = 1'b0;
    logic       enable = 1'b0, tach = 1'b1, enable2 = 1'b0, tach2 = 1'b1;
    logic [7:0] adc, adc2;
    logic       stb, stb2, stall, stall2;
    logic [1:0] st, st2;

    always #5 clk = ~clk;

    fan_tach_meter #(.ADC_BITWIDTH(8), .GATE_TICKS(G), .FILTER_LEN(2)) dut (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(enable), .tach_i(tach),
        .ADC_value_o(adc), .dataValid_STRB_o(stb), .stall_o(stall), .state_o(st));

    fan_tach_meter #(.ADC_BITWIDTH(8), .GATE_TICKS(G2), .FILTER_LEN(2)) dut2 (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .enable_i(enable2), .tach_i(tach2),
        .ADC_value_o(adc2), .dataValid_STRB_o(stb2), .stall_o(stall2), .state_o(st2));

    int n_run = 0, n_fail = 0;
    int div = 0, mode = NOM;
    int k = 0, pk = 0, k2 = 0, pk2 = 0;
    bit on1 = 0, on2 = 0, en_req = 0, en2_req = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Tach level driven for window tick kk (ticks counted from 1 after enable).
    function automatic logic pat(input int m, input int kk);
        case (m)
            NOM:     return !((kk % 5) == 0 || (kk % 5) == 1);
            GLI:     return (kk % 3) != 0;
            default: return !(kk == 10 || kk == 11 || kk == 14 || kk == 15 ||
                              kk == 18 || kk == 19);
        endcase
    endfunction

    function automatic int exp_val(input int m, input int kk);
        case (m)
            NOM:     return 2;
            GLI:     return 0;
            default: return (kk == 20) ? 3 : 0;
        endcase
    endfunction

    // One clk cycle: check what the last posedge produced, then drive the next.
    task automatic step();
        @(negedge clk);
        if (pk != 0 && pk % G == 0 && pk >= 2 * G) begin
            chk("strobe", stb, 1);
            chk("value", adc, exp_val(mode, pk));
            chk("stall", stall, exp_val(mode, pk) == 0);
        end else begin
            chk("no_strobe", stb, 0);
        end
        if (pk2 != 0 && pk2 % G2 == 0 && pk2 >= 2 * G2) begin
            chk("sat_strobe", stb2, 1);
            chk("sat_value", adc2, 255);
            chk("sat_stall", stall2, 0);
        end else begin
            chk("sat_no_strobe", stb2, 0);
        end
        div++;
        clk_en  = (div % 4 == 0);
        enable  = en_req;
        enable2 = en2_req;
        pk = 0;
        if (on1 && en_req && clk_en) begin
            k++;
            pk = k;
            tach = pat(mode, k);
        end else if (!on1 && en_req) begin
            k = 0;
        end
        on1 = en_req;
        pk2 = 0;
        if (on2 && en2_req && clk_en) begin
            k2++;
            pk2 = k2;
            tach2 = ((k2 % 4) < 2) ? 1'b0 : 1'b1;
        end else if (!on2 && en2_req) begin
            k2 = 0;
        end
        on2 = en2_req;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_adc", adc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_stall", stall, 0);
        chk("rst_state", st, 0);
        clk_en = 1'b0;
        #1 rstn = 1'b1;
        // The next posedge takes IDLE -> WARMUP without a tick.
        on1 = en_req;
        k   = 0;
        pk  = 0;
    endtask

    initial begin
        #1;
        chk("init_adc", adc, 0);
        chk("init_stb", stb, 0);
        chk("init_stall", stall, 0);
        chk("init_state", st, 0);
        @(negedge clk);
        #2 rstn = 1'b1;

        mode = NOM; en_req = 1;
        while (k < 46) step();
        en_req = 0;
        step();
        step();
        chk("abort_state", st, 0);
        chk("abort_hold_adc", adc, 2);
        chk("abort_hold_stall", stall, 0);
        repeat (8) step();

        en_req = 1;
        step();
        step();
        chk("reenable_warmup", st, 1);
        while (k < 15) step();
        chk("count_state", st, 2);
        rst_pulse();
        while (k < 40) step();
        repeat (3) step();

        en_req = 0;
        repeat (2) step();
        mode = GLI; en_req = 1;
        while (k < 40) step();
        repeat (3) step();

        en_req = 0;
        repeat (2) step();
        mode = BND; en_req = 1;
        while (k < 30) step();
        repeat (3) step();

        en_req = 0; en2_req = 1;
        while (k2 < 2 * G2) step();
        repeat (3) step();
        chk("sat_final_adc", adc2, 255);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
